rs_enc_16_8: RTL

Systematic RS(16,8) encoder over GF(256), t=4. It is the transmit-side counterpart of the RS(16,8) decoder chain (syndrome, key equation, Chien, Forney).
- Accepts 8 message symbols on a valid/ready stream.
- Passes them through unchanged, then appends 8 parity symbols from an LFSR division by g(x).
- Field: primitive polynomial 0x11D. Generator roots: g(x) = Π_{i=1..8}(x + α^i). These match the decoder's syndrome roots α^{idx+1}.

---
 rtl/rs_16_8_pkg.sv | 76 +++++++
 rtl/gf_mul_const_8.sv | 20 ++
 rtl/rs_enc_16_8.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rs_16_8_pkg.sv
// ---------------------------------------------------------------------------
// rs_16_8_pkg
//   Shared definitions for the RS(16,8) codec over GF(256), t = 4.
//   - Field: primitive polynomial 0x11D, alpha = 0x02.
//   - GEN_COEF: low coefficients g0..g7 of the monic generator
//       g(x) = prod_{i=1..8} (x + alpha^i)
//     The roots alpha^1..alpha^8 are the decoder's syndrome roots, so every
//     codeword this encoder produces has all-zero syndromes.
//   - state_t: encoder sequencing states.
//   - gf_mul: exact GF(256) multiply (shift-and-add, reduced mod 0x11D).
// ---------------------------------------------------------------------------
package rs_16_8_pkg;

    localparam int RS_SYM_BW = 8;   // symbol width; the field tables assume 8
    localparam int RS_N_NUM  = 16;  // codeword length in symbols
    localparam int RS_R_NUM  = 8;   // parity symbols per codeword (2t)

    localparam logic [8:0] PRIM_POLY = 9'h11D;

    typedef logic [RS_R_NUM-1:0][RS_SYM_BW-1:0] coef_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Shift-and-add multiply: for each set bit of b, add the running a*x^i,
    // reducing a*x by the primitive polynomial whenever it overflows bit 7.
    // A zero operand gives zero because nothing is ever accumulated.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end
            if (aa[7]) begin
                aa = (aa << 1) ^ PRIM_POLY[7:0];
            end else begin
                aa = aa << 1;
            end
        end
        return acc;
    endfunction

    // Expands prod (x + alpha^i), i = 1..8, one root at a time.
    // c[] holds the running product, c[0] being the constant term; the x^8
    // coefficient is always 1 and is not returned.
    function automatic coef_vec_t gen_poly();
        logic [RS_R_NUM:0][7:0] c;
        logic [7:0]             root;
        coef_vec_t              res;
        c    = '0;
        c[0] = 8'h01;
        root = 8'h01;
        for (int i = 1; i <= RS_R_NUM; i++) begin
            root = gf_mul(root, 8'h02);
            for (int j = i; j >= 1; j--) begin
                c[j] = c[j-1] ^ gf_mul(c[j], root);
            end
            c[0] = gf_mul(c[0], root);
        end
        for (int k = 0; k < RS_R_NUM; k++) begin
            res[k] = c[k];
        end
        return res;
    endfunction

    // Generator coefficients, evaluated once at elaboration.
    localparam coef_vec_t GEN_COEF = gen_poly();

endpackage

// File: rtl/gf_mul_const_8.sv
// ---------------------------------------------------------------------------
// gf_mul_const_8
//   Combinational GF(256) multiply of a symbol by a fixed coefficient.
//   With COEF a constant the whole function collapses to an 8x8 XOR matrix.
//   Ports:
//     sym   in  8  multiplicand
//     prod  out 8  sym * COEF in GF(256) mod 0x11D
// ---------------------------------------------------------------------------
module gf_mul_const_8
    import rs_16_8_pkg::*;
#(
    parameter logic [7:0] COEF = 8'h01
) (
    input  logic [7:0] sym,
    output logic [7:0] prod
);

    assign prod = gf_mul(sym, COEF);

endmodule

// File: rtl/rs_enc_16_8.sv
// ---------------------------------------------------------------------------
// rs_enc_16_8
//   Systematic RS(16,8) encoder over GF(256). Eight message symbols pass
//   straight through, then the eight parity symbols left in the division
//   LFSR (remainder of m(x)*x^8 mod g(x)) are shifted out, highest degree
//   first. A single output register sits between the LFSR and the stream.
//   Ports:
//     clk        in   1       rising-edge clock
//     rst        in   1       synchronous active-high reset
//     in_valid   in   1       message symbol valid
//     in_ready   out  1       symbol is accepted this cycle
//     in_data    in   SYM_BW  message symbol, x^15 position first
//     out_valid  out  1       out_data valid
//     out_ready  in   1       downstream takes out_data this cycle
//     out_data   out  SYM_BW  codeword symbol (8 message, then 8 parity)
//     out_sop    out  1       first codeword symbol
//     out_eop    out  1       last parity symbol
//     busy       out  1       a codeword is in flight
// ---------------------------------------------------------------------------
module rs_enc_16_8
    import rs_16_8_pkg::*;
#(
    parameter int SYM_BW = RS_SYM_BW,
    parameter int N_NUM  = RS_N_NUM,
    parameter int R_NUM  = RS_R_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SYM_BW-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SYM_BW-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy
);

    localparam logic [3:0] CNT_LAST_MSG = 4'(R_NUM - 1);
    localparam logic [3:0] CNT_LAST_SYM = 4'(N_NUM - 1);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [SYM_BW-1:0] par_reg  [R_NUM];
    logic [SYM_BW-1:0] par_next [R_NUM];
    logic [SYM_BW-1:0] par_old  [R_NUM];
    logic [SYM_BW-1:0] par_upd  [R_NUM];
    logic [SYM_BW-1:0] prod     [R_NUM];
    logic [SYM_BW-1:0] fb;

    logic              out_valid_reg, out_valid_next;
    logic [SYM_BW-1:0] out_data_reg,  out_data_next;
    logic              out_sop_reg,   out_sop_next;
    logic              out_eop_reg,   out_eop_next;
    logic              busy_reg,      busy_next;

    logic              free;
    logic              in_fire;

    // The output register can take a new beat when empty or draining now.
    assign free     = !out_valid_reg || out_ready;
    assign in_ready = ((state_reg == IDLE) || (state_reg == MSG)) && free;
    assign in_fire  = in_valid && in_ready;

    // Division LFSR next value for an accepted message symbol. The first
    // symbol of a word (accepted in IDLE) sees an all-zero register, so a
    // previous or aborted word can never leak into the new parity.
    generate
        for (genvar gi = 0; gi < R_NUM; gi++) begin : g_lfsr
            assign par_old[gi] = (state_reg == IDLE) ? '0 : par_reg[gi];

            gf_mul_const_8 #(
                .COEF (GEN_COEF[gi])
            ) u_mul (
                .sym  (fb),
                .prod (prod[gi])
            );

            if (gi == 0) begin : g_low
                assign par_upd[gi] = prod[gi];
            end else begin : g_high
                assign par_upd[gi] = par_old[gi-1] ^ prod[gi];
            end
        end
    endgenerate

    assign fb = in_data ^ par_old[R_NUM-1];

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg && !out_ready;
        out_data_next  = out_data_reg;
        out_sop_next   = out_sop_reg;
        out_eop_next   = out_eop_reg;
        busy_next      = busy_reg;
        for (int j = 0; j < R_NUM; j++) begin
            par_next[j] = par_reg[j];
        end

        case (state_reg)
            IDLE: begin
                if (in_fire) begin
                    state_next     = MSG;
                    cnt_next       = 4'd1;
                    out_valid_next = 1'b1;
                    out_data_next  = in_data;
                    out_sop_next   = 1'b1;
                    out_eop_next   = 1'b0;
                    busy_next      = 1'b1;
                    for (int j = 0; j < R_NUM; j++) begin
                        par_next[j] = par_upd[j];
                    end
                end
            end

            MSG: begin
                if (in_fire) begin
                    cnt_next       = cnt_reg + 4'd1;
                    out_valid_next = 1'b1;
                    out_data_next  = in_data;
                    out_sop_next   = 1'b0;
                    out_eop_next   = 1'b0;
                    for (int j = 0; j < R_NUM; j++) begin
                        par_next[j] = par_upd[j];
                    end
                    if (cnt_reg == CNT_LAST_MSG) begin
                        state_next = PAR;
                    end
                end
            end

            PAR: begin
                // Parity drains from the top of the register; the LFSR and
                // the counter only move when the beat can be loaded.
                if (free) begin
                    cnt_next       = cnt_reg + 4'd1;
                    out_valid_next = 1'b1;
                    out_data_next  = par_reg[R_NUM-1];
                    out_sop_next   = 1'b0;
                    out_eop_next   = (cnt_reg == CNT_LAST_SYM);
                    par_next[0]    = '0;
                    for (int j = 1; j < R_NUM; j++) begin
                        par_next[j] = par_reg[j-1];
                    end
                    if (cnt_reg == CNT_LAST_SYM) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                // The eop beat sits in the output register; once it is
                // taken the encoder is idle and free for the next word.
                if (out_ready) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                    busy_next  = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            for (int j = 0; j < R_NUM; j++) begin
                par_reg[j] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_sop_reg   <= out_sop_next;
            out_eop_reg   <= out_eop_next;
            busy_reg      <= busy_next;
            for (int j = 0; j < R_NUM; j++) begin
                par_reg[j] <= par_next[j];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sop   = out_sop_reg;
    assign out_eop   = out_eop_reg;
    assign busy      = busy_reg;

endmodule
